// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the step counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam logic [4:0] BCD_BASE = 5'd10;

    function automatic logic is_bcd(input bcd_digit_t nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD decade: adds (dir=0) or subtracts (dir=1) step plus incoming carry/borrow.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [3:0] step,
    input  logic       dir,
    input  logic       cin,
    output logic [3:0] result,
    output logic       cout
);

    logic [4:0] amt;
    logic [4:0] sum;

    always_comb begin
        amt  = {1'b0, step} + {4'b0000, cin};
        sum  = 5'd0;
        cout = 1'b0;
        if (!dir) begin
            sum = {1'b0, digit} + amt;
            if (sum > {1'b0, BCD_MAX}) begin
                sum  = sum - BCD_BASE;
                cout = 1'b1;
            end
        end else if ({1'b0, digit} < amt) begin
            sum  = {1'b0, digit} + BCD_BASE - amt;
            cout = 1'b1;
        end else begin
            sum = {1'b0, digit} - amt;
        end
        result = sum[3:0];
    end

endmodule

// File: rtl/bcd_step_counter.sv
// Multi-decade BCD up/down counter stepping by STEP, with wrap or saturate on overflow,
// synchronous clamping load and one-cycle boundary pulses.
module bcd_step_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned STEP   = 2,
    parameter int unsigned WRAP   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                add,
    input  logic                sub,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic [4*DIGITS-1:0] q_n,
    output logic                increment,
    output logic                decrement,
    output logic                at_max,
    output logic                at_zero,
    output logic                load_err
);

    localparam int unsigned W           = 4 * DIGITS;
    localparam bcd_digit_t  STEP_NIB    = bcd_digit_t'(STEP);
    localparam logic [W-1:0] ALL_NINES  = {DIGITS{BCD_MAX}};

    logic [W-1:0]    cnt_q, cnt_d;
    logic            inc_q, inc_d;
    logic            dec_q, dec_d;
    logic            err_q, err_d;
    logic            active_q, active_d;

    logic [DIGITS:0] carry;
    logic [W-1:0]    chain_sum;
    logic [W-1:0]    load_fix;
    logic            load_bad;
    logic            step_op;

    assign carry[0] = 1'b0;

    // Only decade 0 receives STEP; higher decades just absorb the carry/borrow.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        localparam bcd_digit_t DSTEP = (i == 0) ? STEP_NIB : 4'd0;
        bcd_digit_step u_step (
            .digit  (cnt_q[4*i +: 4]),
            .step   (DSTEP),
            .dir    (sub),
            .cin    (carry[i]),
            .result (chain_sum[4*i +: 4]),
            .cout   (carry[i+1])
        );
    end

    always_comb begin
        load_fix = '0;
        load_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (is_bcd(load_val[4*k +: 4])) begin
                load_fix[4*k +: 4] = load_val[4*k +: 4];
            end else begin
                load_fix[4*k +: 4] = BCD_MAX;
                load_bad           = 1'b1;
            end
        end
    end

    // add and sub together cancel out and are ignored entirely.
    assign step_op = add ^ sub;

    always_comb begin
        cnt_d    = cnt_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        err_d    = 1'b0;
        active_d = active_q;
        if (load) begin
            cnt_d    = load_fix;
            err_d    = load_bad;
            active_d = 1'b1;
        end else if (step_op) begin
            active_d = 1'b1;
            cnt_d    = chain_sum;
            if (carry[DIGITS]) begin
                inc_d = add;
                dec_d = sub;
                if (WRAP == 0) begin
                    cnt_d = add ? ALL_NINES : '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign q         = cnt_q;
    assign q_n       = active_q ? ~cnt_q : '0;
    assign increment = inc_q;
    assign decrement = dec_q;
    assign load_err  = err_q;
    assign at_max    = (cnt_q == ALL_NINES);
    assign at_zero   = (cnt_q == '0);

endmodule

// File: tb/tb_bcd_step_counter.sv
// Bench: a wrapping and a saturating 2-digit, step-2 counter driven with identical stimulus.
module tb_bcd_step_counter;

    typedef struct {
        logic       a;
        logic       s;
        logic       l;
        logic [7:0] lv;
        logic [7:0] qw;
        logic [2:0] fw;
        logic [7:0] qs;
        logic [2:0] fs;
    } vec_t;

    // flags are {increment, decrement, load_err}
    typedef struct {
        logic [7:0] qw;
        logic [2:0] fw;
        logic [7:0] qs;
        logic [2:0] fs;
        logic       act;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       add, sub, load;
    logic [7:0] load_val;

    logic [7:0] qw, qnw, qs, qns;
    logic       incw, decw, maxw, zerow, errw;
    logic       incs, decs, maxs, zeros, errs;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sbq[$];

    bcd_step_counter #(.DIGITS(2), .STEP(2), .WRAP(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .add(add), .sub(sub), .load(load), .load_val(load_val),
        .q(qw), .q_n(qnw), .increment(incw), .decrement(decw), .at_max(maxw),
        .at_zero(zerow), .load_err(errw)
    );

    bcd_step_counter #(.DIGITS(2), .STEP(2), .WRAP(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .add(add), .sub(sub), .load(load), .load_val(load_val),
        .q(qs), .q_n(qns), .increment(incs), .decrement(decs), .at_max(maxs),
        .at_zero(zeros), .load_err(errs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    task automatic check_both(input exp_t e);
        logic [7:0] qn_w, qn_s;
        qn_w = e.act ? ~e.qw : 8'h00;
        qn_s = e.act ? ~e.qs : 8'h00;
        chk("q_wrap", {24'd0, qw}, {24'd0, e.qw});
        chk("flags_wrap", {29'd0, incw, decw, errw}, {29'd0, e.fw});
        chk("at_max_wrap", {31'd0, maxw}, {31'd0, e.qw == 8'h99});
        chk("at_zero_wrap", {31'd0, zerow}, {31'd0, e.qw == 8'h00});
        chk("q_n_wrap", {24'd0, qnw}, {24'd0, qn_w});
        chk("q_sat", {24'd0, qs}, {24'd0, e.qs});
        chk("flags_sat", {29'd0, incs, decs, errs}, {29'd0, e.fs});
        chk("at_max_sat", {31'd0, maxs}, {31'd0, e.qs == 8'h99});
        chk("at_zero_sat", {31'd0, zeros}, {31'd0, e.qs == 8'h00});
        chk("q_n_sat", {24'd0, qns}, {24'd0, qn_s});
    endtask

    task automatic cycle(input logic a, input logic s, input logic l, input logic [7:0] lv,
                         input exp_t e);
        exp_t got;
        add      = a;
        sub      = s;
        load     = l;
        load_val = lv;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = sbq.pop_front();
            check_both(got);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // Integer reference model of one 2-digit, step-2 update.
    function automatic void model(input int v, input bit wrap, input logic a, input logic s,
                                  input logic l, input logic [7:0] lv,
                                  output int nv, output logic [2:0] f);
        int hi, lo;
        nv = v;
        f  = 3'b000;
        if (l) begin
            hi = int'(lv[7:4]);
            lo = int'(lv[3:0]);
            if (hi > 9) begin hi = 9; f[0] = 1'b1; end
            if (lo > 9) begin lo = 9; f[0] = 1'b1; end
            nv = hi * 10 + lo;
        end else if (a && !s) begin
            if (v + 2 > 99) begin
                f[2] = 1'b1;
                nv   = wrap ? v + 2 - 100 : 99;
            end else nv = v + 2;
        end else if (s && !a) begin
            if (v - 2 < 0) begin
                f[1] = 1'b1;
                nv   = wrap ? v + 98 : 0;
            end else nv = v - 2;
        end
    endfunction

    vec_t vecs[24];
    exp_t e;
    logic act_flag;
    int   vw, vs, nvw, nvs;
    logic [2:0] fw, fs;

    initial begin
        vecs = '{
            '{0, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00, 3'b000},
            '{1, 0, 0, 8'h00, 8'h02, 3'b000, 8'h02, 3'b000},
            '{1, 0, 0, 8'h00, 8'h04, 3'b000, 8'h04, 3'b000},
            '{1, 0, 0, 8'h00, 8'h06, 3'b000, 8'h06, 3'b000},
            '{1, 0, 0, 8'h00, 8'h08, 3'b000, 8'h08, 3'b000},
            '{1, 0, 0, 8'h00, 8'h10, 3'b000, 8'h10, 3'b000},
            '{0, 0, 1, 8'h98, 8'h98, 3'b000, 8'h98, 3'b000},
            '{1, 0, 0, 8'h00, 8'h00, 3'b100, 8'h99, 3'b100},
            '{1, 0, 0, 8'h00, 8'h02, 3'b000, 8'h99, 3'b100},
            '{0, 0, 1, 8'h01, 8'h01, 3'b000, 8'h01, 3'b000},
            '{0, 1, 0, 8'h00, 8'h99, 3'b010, 8'h00, 3'b010},
            '{0, 1, 0, 8'h00, 8'h97, 3'b000, 8'h00, 3'b010},
            '{0, 0, 1, 8'h97, 8'h97, 3'b000, 8'h97, 3'b000},
            '{1, 0, 0, 8'h00, 8'h99, 3'b000, 8'h99, 3'b000},
            '{1, 0, 0, 8'h00, 8'h01, 3'b100, 8'h99, 3'b100},
            '{1, 0, 1, 8'hA3, 8'h93, 3'b001, 8'h93, 3'b001},
            '{0, 0, 0, 8'h00, 8'h93, 3'b000, 8'h93, 3'b000},
            '{0, 0, 1, 8'h50, 8'h50, 3'b000, 8'h50, 3'b000},
            '{1, 1, 0, 8'h00, 8'h50, 3'b000, 8'h50, 3'b000},
            '{0, 0, 0, 8'h00, 8'h50, 3'b000, 8'h50, 3'b000},
            '{0, 0, 1, 8'hFF, 8'h99, 3'b001, 8'h99, 3'b001},
            '{0, 0, 1, 8'h0C, 8'h09, 3'b001, 8'h09, 3'b001},
            '{0, 1, 1, 8'h20, 8'h20, 3'b000, 8'h20, 3'b000},
            '{0, 1, 0, 8'h00, 8'h18, 3'b000, 8'h18, 3'b000}
        };

        rst_n    = 1'b0;
        add      = 1'b0;
        sub      = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        act_flag = 1'b0;

        #12;
        e = '{8'h00, 3'b000, 8'h00, 3'b000, 1'b0};
        check_both(e);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            act_flag = act_flag | vecs[i].l | (vecs[i].a ^ vecs[i].s);
            e = '{vecs[i].qw, vecs[i].fw, vecs[i].qs, vecs[i].fs, act_flag};
            cycle(vecs[i].a, vecs[i].s, vecs[i].l, vecs[i].lv, e);
        end

        vw = 18;
        vs = 18;
        for (int i = 0; i < 40; i++) begin
            logic a, s, l;
            logic [7:0] lv;
            a  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            l  = ($urandom_range(0, 7) == 0);
            lv = 8'($urandom_range(0, 255));
            model(vw, 1'b1, a, s, l, lv, nvw, fw);
            model(vs, 1'b0, a, s, l, lv, nvs, fs);
            vw = nvw;
            vs = nvs;
            act_flag = act_flag | l | (a ^ s);
            e = '{to_bcd(vw), fw, to_bcd(vs), fs, act_flag};
            cycle(a, s, l, lv, e);
        end

        // Asynchronous reset in the middle of a cycle with an add pending.
        cycle(1'b0, 1'b0, 1'b1, 8'h50, '{8'h50, 3'b000, 8'h50, 3'b000, 1'b1});
        add = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_q_wrap", {24'd0, qw}, 32'd0);
        chk("async_rst_q_n_wrap", {24'd0, qnw}, 32'd0);
        chk("async_rst_q_sat", {24'd0, qs}, 32'd0);
        chk("async_rst_q_n_sat", {24'd0, qns}, 32'd0);
        add = 1'b0;
        #3;
        rst_n    = 1'b1;
        act_flag = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 8'h00, '{8'h00, 3'b000, 8'h00, 3'b000, 1'b0});
        cycle(1'b1, 1'b0, 1'b0, 8'h00, '{8'h02, 3'b000, 8'h02, 3'b000, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
